ps2_receiver: RTL and testbench
===============================

PS2_RECEIVER -- requirements
Module: ps2_receiver

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 50000, giving the clk cycles allowed between PS/2 clock falling edges inside a frame (1 ms at 50 MHz).
REQ-002 SHALL have port clk  input  1  system clock (CLOCK_50 at top level).
REQ-003 SHALL have port reset  input  1  asynchronous active-low reset (KEY at top level).
REQ-004 SHALL have port ps2_clk  input  1  raw PS2_CLK pin, asynchronous to clk.
REQ-005 SHALL have port ps2_dat  input  1  raw PS2_DAT pin, asynchronous to clk.
REQ-006 SHALL have port data_out  output  8  last correctly received scancode byte.
REQ-007 SHALL have port data_valid  output  1  one-cycle pulse: data_out was updated.
REQ-008 SHALL have port parity_err  output  1  one-cycle pulse: odd-parity check failed.
REQ-009 SHALL have port frame_err  output  1  one-cycle pulse: stop bit 0 or inter-edge timeout.
REQ-010 SHALL have port busy  output  1  high while a frame is in progress (state != IDLE).
REQ-011 SHALL use one clock, clk; reset is asynchronous and active-low.

Function
REQ-012 SHALL pass ps2_clk and ps2_dat each through a 2-flop synchronizer; all logic uses only the synchronized values.
REQ-013 SHALL hold a register of the previous synchronized ps2_clk; falling edge = previous 1 and current 0; data is sampled from synchronized ps2_dat in that same cycle.
REQ-014 SHALL implement states IDLE, DATA, PARITY, STOP.
REQ-015 IDLE: falling edge with dat=0 (start bit) -> DATA, bit counter 0, timeout counter 0; falling edge with dat=1 -> ignored, remain IDLE.
REQ-016 DATA: each falling edge shifts dat in LSB-first; after the 8th bit (counter 7) -> PARITY.
REQ-017 PARITY: next falling edge stores the parity bit -> STOP.
REQ-018 STOP: next falling edge evaluates in priority order: dat=0 -> frame_err; else odd parity fails (ones in 8 data bits + parity bit is even) -> parity_err; else data_out <= shifted byte and data_valid. Then -> IDLE in all cases.
REQ-019 SHALL register the error/valid pulses high exactly in the clk cycle after the stop-bit edge cycle, for one cycle only; at most one of data_valid, parity_err, frame_err SHALL be high in any cycle.
REQ-020 SHALL leave data_out unchanged on parity_err, frame_err, or timeout.
REQ-021 In DATA, PARITY, STOP: timeout counter increments every clk cycle and clears on each falling edge; reaching TIMEOUT_CYCLES-1 without an edge -> IDLE and one-cycle frame_err, partial byte discarded.
REQ-022 Timeout counter width SHALL be $clog2(TIMEOUT_CYCLES) bits; it never wraps (saturates by the forced return to IDLE).
REQ-023 A falling edge in the same cycle as timeout expiry SHALL win: the edge is processed, counter clears, no frame_err.
REQ-024 busy SHALL be combinational from state: 0 in IDLE, 1 otherwise.
REQ-025 Latency: ps2_clk pin fall to edge detection 2-3 clk cycles; data_valid 1 cycle after detection of the stop-bit edge.

Reset
REQ-026 reset=0 SHALL immediately force state IDLE, data_out=8'h00, data_valid=0, parity_err=0, frame_err=0, busy=0, synchronizers and previous-clk register to 1, shift register/counters to 0.
REQ-027 Reset mid-frame SHALL discard the partial frame with no pulse; after release, reception restarts only on a new start bit.

Verification
REQ-028 Valid frame 0x1C (start 0, bits 0,0,1,1,1,0,0,0, parity 0, stop 1), PS/2 clock ~12.5 kHz -> data_out=0x1C, data_valid exactly one cycle, no error pulse, busy low afterwards.
REQ-029 Frame 0x1C with parity bit 1 -> parity_err one cycle, data_out keeps previous value (0x00 after reset), no data_valid.
REQ-030 Frame 0x5A with stop bit 0 -> frame_err one cycle, data_out unchanged; following valid 0xF0 -> data_out=0xF0, data_valid.
REQ-031 Stop ps2_clk after 4 data bits, TIMEOUT_CYCLES=100 -> frame_err pulse about 100 cycles after the last edge, busy drops; next valid 0x29 received correctly.
REQ-032 Assert reset after 6 data bits -> all outputs 0 at once, no pulse; after release a full 0x1C frame -> data_valid, data_out=0x1C.
REQ-033 Falling edge with ps2_dat=1 in IDLE, then valid 0x76 -> first edge ignored (busy stays 0), data_out=0x76.

Source files
------------

// File: rtl/ps2_receiver.sv
// PS/2 device-to-host frame receiver: synchronizes the raw PS/2 pins, assembles
// 11-bit frames on ps2_clk falling edges and reports bytes or errors as one-cycle pulses.
module ps2_receiver #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  state_t        state_q;
  logic          clk_s1_q, clk_s2_q, clk_prev_q;
  logic          dat_s1_q, dat_s2_q;
  logic [2:0]    bit_cnt_q;
  logic [7:0]    shift_q;
  logic          parity_q;
  logic [TW-1:0] tmo_q;
  logic [7:0]    data_out_q;
  logic          valid_q, perr_q, ferr_q;

  logic          fall_s;
  logic          dat_s;
  logic          tmo_expired_s;

  // Odd parity holds when data plus parity bit carry an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction

  assign fall_s        = clk_prev_q & ~clk_s2_q;
  assign dat_s         = dat_s2_q;
  assign tmo_expired_s = (tmo_q == TW'(TIMEOUT_CYCLES - 1));

  // Two-flop synchronizers for both pins plus the previous-clock register for edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
    end else begin
      clk_s1_q   <= ps2_clk;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      dat_s1_q   <= ps2_dat;
      dat_s2_q   <= dat_s1_q;
    end
  end

  // Frame FSM with registered byte and status pulses; an edge always beats a timeout.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'h00;
      parity_q   <= 1'b0;
      tmo_q      <= '0;
      data_out_q <= 8'h00;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          tmo_q <= '0;
          if (fall_s && !dat_s) begin
            state_q   <= DATA;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'h00;
          end else begin
            state_q <= IDLE;
          end
        end
        DATA: begin
          if (fall_s) begin
            tmo_q   <= '0;
            shift_q <= {dat_s, shift_q[7:1]};
            if (bit_cnt_q == 3'd7) begin
              state_q <= PARITY;
            end else begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
            end
          end else if (tmo_expired_s) begin
            state_q <= IDLE;
            ferr_q  <= 1'b1;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        PARITY: begin
          if (fall_s) begin
            tmo_q    <= '0;
            parity_q <= dat_s;
            state_q  <= STOP;
          end else if (tmo_expired_s) begin
            state_q <= IDLE;
            ferr_q  <= 1'b1;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        STOP: begin
          if (fall_s) begin
            tmo_q   <= '0;
            state_q <= IDLE;
            if (!dat_s) begin
              ferr_q <= 1'b1;
            end else if (!odd_parity_ok(shift_q, parity_q)) begin
              perr_q <= 1'b1;
            end else begin
              data_out_q <= shift_q;
              valid_q    <= 1'b1;
            end
          end else if (tmo_expired_s) begin
            state_q <= IDLE;
            ferr_q  <= 1'b1;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          tmo_q   <= '0;
        end
      endcase
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_ps2_receiver.sv
// Scoreboard bench for ps2_receiver: expected events are queued as frames are driven
// and matched against the data_valid / parity_err / frame_err pulses.
module tb_ps2_receiver;

  localparam int TMO = 100;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic [7:0] data_out;
  logic       data_valid, parity_err, frame_err, busy;

  typedef struct {
    logic [2:0] kind;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         last_fall_cyc = 0;
  int         ferr_cyc = 0;
  logic [7:0] last_good = 8'h00;
  logic [2:0] prev_ev = 3'b000;

  ps2_receiver #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
    .data_out(data_out), .data_valid(data_valid), .parity_err(parity_err),
    .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor: each pulse must be one-hot, single-cycle, and match the queue head.
  always @(negedge clk) begin
    logic [2:0] ev;
    exp_t e;
    ev = {data_valid, parity_err, frame_err};
    if (ev !== 3'b000) begin
      if (frame_err === 1'b1) ferr_cyc = cyc;
      total++;
      if (ev !== 3'b100 && ev !== 3'b010 && ev !== 3'b001) begin
        bad++;
        $display("FAIL onehot: pulses(valid,perr,ferr)=%b required one-hot", ev);
      end
      total++;
      if (prev_ev !== 3'b000) begin
        bad++;
        $display("FAIL pulse_width: previous cycle pulses=%b required 000", prev_ev);
      end
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_pulse: pulses=%b data_out=%h required none", ev, data_out);
      end else begin
        e = exp_q.pop_front();
        if (ev !== e.kind || data_out !== e.data) begin
          bad++;
          $display("FAIL event: pulses=%b data_out=%h required pulses=%b data_out=%h",
                   ev, data_out, e.kind, e.data);
        end
      end
    end
    prev_ev = ev;
  end

  task automatic ps2_bit(input logic b);
    @(negedge clk);
    ps2_dat = b;
    repeat (10) @(negedge clk);
    ps2_clk = 1'b0;
    last_fall_cyc = cyc;
    repeat (20) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic push_expect(input logic [7:0] d, input logic par, input logic stp);
    exp_t e;
    if (!stp) begin
      e.kind = 3'b001; e.data = last_good;
    end else if ((^{d, par}) == 1'b0) begin
      e.kind = 3'b010; e.data = last_good;
    end else begin
      e.kind = 3'b100; e.data = d; last_good = d;
    end
    exp_q.push_back(e);
  endtask

  task automatic send_payload(input logic [7:0] d, input logic par, input logic stp);
    for (int i = 0; i < 8; i++) ps2_bit(d[i]);
    ps2_bit(par);
    ps2_bit(stp);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp);
    push_expect(d, par, stp);
    ps2_bit(1'b0);
    send_payload(d, par, stp);
  endtask

  task automatic drain(output logic ok);
    for (int i = 0; i < 400; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    ok = (exp_q.size() == 0);
    if (!ok) exp_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #1;
    total++;
    if ({data_out, data_valid, parity_err, frame_err, busy} !== 12'h000) begin
      bad++;
      $display("FAIL reset_outputs: got %h required 000", {data_out, data_valid, parity_err, frame_err, busy});
    end
    repeat (5) @(negedge clk);
    reset = 1'b1;
    last_good = 8'h00;
    repeat (5) @(negedge clk);
    total++;
    if (busy !== 1'b0 || data_out !== 8'h00) begin
      bad++;
      $display("FAIL after_reset: busy=%b data_out=%h required 0/00", busy, data_out);
    end
  endtask

  task automatic test_parity_error();
    logic ok;
    send_frame(8'h1C, 1'b1, 1'b1);
    drain(ok);
    total++;
    if (ok !== 1'b1) begin bad++; $display("FAIL parity_pulse: got none required parity_err"); end
    total++;
    if (data_out !== 8'h00) begin bad++; $display("FAIL parity_keep: data_out=%h required 00", data_out); end
  endtask

  task automatic test_valid();
    logic ok;
    push_expect(8'h1C, 1'b0, 1'b1);
    ps2_bit(1'b0);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL busy_in_frame: busy=%b required 1", busy); end
    send_payload(8'h1C, 1'b0, 1'b1);
    drain(ok);
    total++;
    if (ok !== 1'b1) begin bad++; $display("FAIL valid_pulse: got none required data_valid"); end
    total++;
    if (data_out !== 8'h1C) begin bad++; $display("FAIL valid_data: data_out=%h required 1c", data_out); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL busy_after: busy=%b required 0", busy); end
  endtask

  task automatic test_frame_error();
    logic ok;
    logic [7:0] keep;
    keep = last_good;
    send_frame(8'h5A, ~^8'h5A, 1'b0);
    drain(ok);
    total++;
    if (ok !== 1'b1 || data_out !== keep) begin
      bad++;
      $display("FAIL frame_err: drained=%b data_out=%h required 1/%h", ok, data_out, keep);
    end
    send_frame(8'hF0, ~^8'hF0, 1'b1);
    drain(ok);
    total++;
    if (ok !== 1'b1 || data_out !== 8'hF0) begin
      bad++;
      $display("FAIL after_frame_err: drained=%b data_out=%h required 1/f0", ok, data_out);
    end
  endtask

  task automatic test_timeout();
    logic ok;
    exp_t e;
    int delta;
    e.kind = 3'b001; e.data = last_good;
    exp_q.push_back(e);
    ps2_bit(1'b0);
    ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b1);
    drain(ok);
    delta = ferr_cyc - last_fall_cyc;
    total++;
    if (ok !== 1'b1) begin bad++; $display("FAIL timeout_pulse: got none required frame_err"); end
    total++;
    if (delta < 95 || delta > 110) begin
      bad++;
      $display("FAIL timeout_delay: cycles=%0d required 95..110", delta);
    end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL timeout_busy: busy=%b required 0", busy); end
    send_frame(8'h29, ~^8'h29, 1'b1);
    drain(ok);
    total++;
    if (ok !== 1'b1 || data_out !== 8'h29) begin
      bad++;
      $display("FAIL after_timeout: drained=%b data_out=%h required 1/29", ok, data_out);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic ok;
    ps2_bit(1'b0);
    for (int i = 0; i < 6; i++) ps2_bit(i[0]);
    @(negedge clk);
    reset = 1'b0;
    #1;
    total++;
    if ({data_out, data_valid, parity_err, frame_err, busy} !== 12'h000) begin
      bad++;
      $display("FAIL midframe_reset: got %h required 000", {data_out, data_valid, parity_err, frame_err, busy});
    end
    last_good = 8'h00;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    repeat (150) @(negedge clk);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL midframe_restart: busy=%b required 0", busy); end
    send_frame(8'h1C, 1'b0, 1'b1);
    drain(ok);
    total++;
    if (ok !== 1'b1 || data_out !== 8'h1C) begin
      bad++;
      $display("FAIL midframe_recover: drained=%b data_out=%h required 1/1c", ok, data_out);
    end
  endtask

  task automatic test_ignored_edge();
    logic ok;
    logic seen_busy;
    seen_busy = 1'b0;
    @(negedge clk);
    ps2_dat = 1'b1;
    repeat (10) @(negedge clk);
    ps2_clk = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (i == 20) ps2_clk = 1'b1;
      if (busy === 1'b1) seen_busy = 1'b1;
    end
    total++;
    if (seen_busy !== 1'b0) begin bad++; $display("FAIL idle_edge: busy seen=%b required 0", seen_busy); end
    send_frame(8'h76, ~^8'h76, 1'b1);
    drain(ok);
    total++;
    if (ok !== 1'b1 || data_out !== 8'h76) begin
      bad++;
      $display("FAIL idle_edge_frame: drained=%b data_out=%h required 1/76", ok, data_out);
    end
  endtask

  task automatic test_back_to_back();
    logic ok;
    logic [7:0] d;
    for (int n = 0; n < 4; n++) begin
      d = 8'($urandom_range(0, 255));
      send_frame(d, ~^d, 1'b1);
    end
    drain(ok);
    total++;
    if (ok !== 1'b1 || data_out !== last_good) begin
      bad++;
      $display("FAIL back_to_back: drained=%b data_out=%h required 1/%h", ok, data_out, last_good);
    end
  endtask

  initial begin
    test_reset();
    test_parity_error();
    test_valid();
    test_frame_error();
    test_timeout();
    test_reset_mid_frame();
    test_ignored_edge();
    test_back_to_back();
    repeat (20) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
